// File: rtl/tdm_framer.sv
// 4-bit parallel-to-serial TDM framer. Each word is sent as four slots, MSB first,
// followed by an optional run of idle GAP cycles.
module tdm_framer #(
    parameter int GAP = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic [1:0] key,
    output logic       line_out,
    output logic       frame_sync,
    output logic       busy,
    output logic [7:0] frame_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP
    } state_t;

    localparam logic [3:0] GAP_LOAD = 4'(GAP);

    state_t     state_q, state_d;
    logic [1:0] key_q, key_d;
    logic       line_q, line_d;
    logic       fsync_q, fsync_d;
    logic       busy_q, busy_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] hold_q, hold_d;
    logic [3:0] gapCnt_q, gapCnt_d;
    logic [1:0] keyNext;
    logic       accept;

    // Without a gap, the last slot can take the next word for back-to-back frames.
    always_comb begin
        din_ready = (state_q == ST_IDLE) ||
                    ((state_q == ST_SEND) && (key_q == 2'b11) && (GAP_LOAD == 4'd0));
        accept    = din_valid && din_ready;
        keyNext   = key_q + 2'd1;
    end

    always_comb begin
        state_d  = state_q;
        key_d    = 2'b00;
        line_d   = 1'b0;
        fsync_d  = 1'b0;
        busy_d   = 1'b0;
        cnt_d    = cnt_q;
        hold_d   = hold_q;
        gapCnt_d = gapCnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SEND;
                    hold_d  = din;
                    line_d  = din[3];
                    fsync_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            ST_SEND: begin
                busy_d = 1'b1;
                if (key_q != 2'b11) begin
                    key_d  = keyNext;
                    // Slot k carries bit 3-k, and 3-k equals ~k for a 2-bit slot number.
                    line_d = hold_q[~keyNext];
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (GAP_LOAD != 4'd0) begin
                        state_d  = ST_GAP;
                        gapCnt_d = GAP_LOAD;
                    end else if (accept) begin
                        hold_d  = din;
                        line_d  = din[3];
                        fsync_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            ST_GAP: begin
                busy_d = 1'b1;
                if (gapCnt_q <= 4'd1) begin
                    state_d  = ST_IDLE;
                    busy_d   = 1'b0;
                    gapCnt_d = 4'd0;
                end else begin
                    gapCnt_d = gapCnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            key_q    <= 2'b00;
            line_q   <= 1'b0;
            fsync_q  <= 1'b0;
            busy_q   <= 1'b0;
            cnt_q    <= 8'd0;
            hold_q   <= 4'd0;
            gapCnt_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            line_q   <= line_d;
            fsync_q  <= fsync_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            hold_q   <= hold_d;
            gapCnt_q <= gapCnt_d;
        end
    end

    assign key        = key_q;
    assign line_out   = line_q;
    assign frame_sync = fsync_q;
    assign busy       = busy_q;
    assign frame_cnt  = cnt_q;

endmodule

// File: tb/tb_tdm_framer.sv
// Directed bench for tdm_framer: three instances (GAP=1, GAP=0, GAP=3) share one
// stimulus bus, and each scenario checks only the instance it targets.
module tb_tdm_framer;

    logic       clk = 1'b0;
    logic       rst;
    logic       din_valid;
    logic [3:0] din;

    logic       readyA, lineA, fsA, busyA;
    logic [1:0] keyA;
    logic [7:0] cntA;
    logic       readyB, lineB, fsB, busyB;
    logic [1:0] keyB;
    logic [7:0] cntB;
    logic       readyC, lineC, fsC, busyC;
    logic [1:0] keyC;
    logic [7:0] cntC;

    int assertCount = 0;
    int failCount   = 0;

    always #5 clk = ~clk;

    tdm_framer #(.GAP(1)) dutA (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(readyA),
        .key(keyA), .line_out(lineA), .frame_sync(fsA), .busy(busyA), .frame_cnt(cntA)
    );

    tdm_framer #(.GAP(0)) dutB (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(readyB),
        .key(keyB), .line_out(lineB), .frame_sync(fsB), .busy(busyB), .frame_cnt(cntB)
    );

    tdm_framer #(.GAP(3)) dutC (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(readyC),
        .key(keyC), .line_out(lineC), .frame_sync(fsC), .busy(busyC), .frame_cnt(cntC)
    );

    // Drive inputs for the coming edge, then sample just after it.
    task automatic applyStimulus(input logic r, input logic v, input logic [3:0] d);
        rst       = r;
        din_valid = v;
        din       = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [3:0] w;
        logic [7:0] bits;

        rst = 1'b1; din_valid = 1'b0; din = 4'd0;
        applyStimulus(1'b1, 1'b0, 4'd0);
        applyStimulus(1'b1, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b0, 4'd0);
        checkOutput("rst_key",   8'(keyA),   8'd0);
        checkOutput("rst_line",  8'(lineA),  8'd0);
        checkOutput("rst_fs",    8'(fsA),    8'd0);
        checkOutput("rst_busy",  8'(busyA),  8'd0);
        checkOutput("rst_cnt",   8'(cntA),   8'd0);
        checkOutput("rst_ready", 8'(readyA), 8'd1);

        // Single frame, GAP=1; din is scrambled right after acceptance.
        w = 4'b1011;
        applyStimulus(1'b0, 1'b1, w);
        checkOutput("f1_line0",  8'(lineA),  8'd1);
        checkOutput("f1_key0",   8'(keyA),   8'd0);
        checkOutput("f1_fs0",    8'(fsA),    8'd1);
        checkOutput("f1_busy0",  8'(busyA),  8'd1);
        checkOutput("f1_ready0", 8'(readyA), 8'd0);
        for (int i = 1; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 4'b0000);
            checkOutput("f1_line", 8'(lineA), 8'(w[3-i]));
            checkOutput("f1_key",  8'(keyA),  8'(i));
            checkOutput("f1_fs",   8'(fsA),   8'd0);
        end
        checkOutput("f1_ready3", 8'(readyA), 8'd0);
        applyStimulus(1'b0, 1'b0, 4'd0);
        checkOutput("f1_gap_busy",  8'(busyA),  8'd1);
        checkOutput("f1_gap_ready", 8'(readyA), 8'd0);
        checkOutput("f1_gap_line",  8'(lineA),  8'd0);
        checkOutput("f1_gap_key",   8'(keyA),   8'd0);
        checkOutput("f1_cnt",       8'(cntA),   8'd1);
        applyStimulus(1'b0, 1'b0, 4'd0);
        checkOutput("f1_idle_busy",  8'(busyA),  8'd0);
        checkOutput("f1_idle_ready", 8'(readyA), 8'd1);

        // Backpressure: 0110 offered from slot 01 onward must wait for IDLE.
        applyStimulus(1'b0, 1'b1, 4'b1001);
        checkOutput("bp_a_line0", 8'(lineA), 8'd1);
        applyStimulus(1'b0, 1'b1, 4'b0110);
        checkOutput("bp_a_ready1", 8'(readyA), 8'd0);
        checkOutput("bp_a_line1",  8'(lineA),  8'd0);
        applyStimulus(1'b0, 1'b1, 4'b0110);
        checkOutput("bp_a_line2", 8'(lineA), 8'd0);
        applyStimulus(1'b0, 1'b1, 4'b0110);
        checkOutput("bp_a_line3", 8'(lineA), 8'd1);
        applyStimulus(1'b0, 1'b1, 4'b0110);
        checkOutput("bp_gap_busy", 8'(busyA), 8'd1);
        checkOutput("bp_gap_line", 8'(lineA), 8'd0);
        checkOutput("bp_cnt2",     8'(cntA),  8'd2);
        applyStimulus(1'b0, 1'b1, 4'b0110);
        checkOutput("bp_idle_busy",  8'(busyA),  8'd0);
        checkOutput("bp_idle_ready", 8'(readyA), 8'd1);
        w = 4'b0110;
        applyStimulus(1'b0, 1'b1, w);
        checkOutput("bp_b_line0", 8'(lineA), 8'd0);
        checkOutput("bp_b_fs0",   8'(fsA),   8'd1);
        for (int i = 1; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 4'd0);
            checkOutput("bp_b_line", 8'(lineA), 8'(w[3-i]));
        end
        applyStimulus(1'b0, 1'b0, 4'd0);
        checkOutput("bp_cnt3", 8'(cntA), 8'd3);
        applyStimulus(1'b0, 1'b0, 4'd0);

        // Reset during slot 10 aborts the frame.
        applyStimulus(1'b0, 1'b1, 4'b1111);
        applyStimulus(1'b0, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b0, 4'd0);
        checkOutput("mr_key2", 8'(keyA), 8'd2);
        applyStimulus(1'b1, 1'b0, 4'd0);
        checkOutput("mr_key",   8'(keyA),   8'd0);
        checkOutput("mr_line",  8'(lineA),  8'd0);
        checkOutput("mr_fs",    8'(fsA),    8'd0);
        checkOutput("mr_busy",  8'(busyA),  8'd0);
        checkOutput("mr_cnt",   8'(cntA),   8'd0);
        checkOutput("mr_ready", 8'(readyA), 8'd1);
        applyStimulus(1'b0, 1'b0, 4'd0);
        checkOutput("mr_after_line", 8'(lineA), 8'd0);

        // Reset wins over a simultaneous accept.
        applyStimulus(1'b1, 1'b1, 4'b1111);
        checkOutput("rp_busy", 8'(busyA), 8'd0);
        applyStimulus(1'b0, 1'b0, 4'd0);
        checkOutput("rp_busy2", 8'(busyA), 8'd0);
        checkOutput("rp_line",  8'(lineA), 8'd0);

        // Back-to-back frames on the GAP=0 instance.
        bits = 8'b1000_0001;
        applyStimulus(1'b0, 1'b1, 4'b1000);
        for (int i = 0; i < 8; i++) begin
            checkOutput("b2b_line", 8'(lineB), 8'(bits[7-i]));
            checkOutput("b2b_fs",   8'(fsB),   ((i == 0) || (i == 4)) ? 8'd1 : 8'd0);
            checkOutput("b2b_busy", 8'(busyB), 8'd1);
            if (i == 1) checkOutput("b2b_ready_s1", 8'(readyB), 8'd0);
            if (i == 3) checkOutput("b2b_ready_s3", 8'(readyB), 8'd1);
            if (i < 7) applyStimulus(1'b0, (i < 4), 4'b0001);
        end
        applyStimulus(1'b0, 1'b0, 4'd0);
        checkOutput("b2b_cnt",  8'(cntB),  8'd2);
        checkOutput("b2b_busy_end", 8'(busyB), 8'd0);

        // frame_cnt wrap: frames 3..255 then frame 256.
        applyStimulus(1'b0, 1'b1, 4'b1010);
        repeat (253 * 4) applyStimulus(1'b0, 1'b1, 4'b1010);
        checkOutput("wrap_255", 8'(cntB), 8'd255);
        repeat (4) applyStimulus(1'b0, 1'b1, 4'b1010);
        checkOutput("wrap_0", 8'(cntB), 8'd0);

        // Three-cycle gap on the GAP=3 instance.
        applyStimulus(1'b1, 1'b0, 4'd0);
        w = 4'b0101;
        applyStimulus(1'b0, 1'b1, w);
        checkOutput("g3_line0", 8'(lineC), 8'd0);
        for (int i = 1; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 4'd0);
            checkOutput("g3_line", 8'(lineC), 8'(w[3-i]));
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 4'b1100);
            checkOutput("g3_gap_busy",  8'(busyC),  8'd1);
            checkOutput("g3_gap_ready", 8'(readyC), 8'd0);
        end
        checkOutput("g3_cnt", 8'(cntC), 8'd1);
        applyStimulus(1'b0, 1'b0, 4'd0);
        checkOutput("g3_idle_busy",  8'(busyC),  8'd0);
        checkOutput("g3_idle_ready", 8'(readyC), 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/tdm_framer.md
TDM_FRAMER -- requirements
Module: tdm_framer

Interface
REQ-001 The block SHALL have parameter GAP, default 1, meaning idle cycles inserted between frames (legal 0-15).
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port din  input  4  parallel word to serialize, bit 3 sent first.
REQ-005 The block SHALL have port din_valid  input  1  upstream asserts when din holds a word.
REQ-006 The block SHALL have port din_ready  output  1  block can accept din this cycle.
REQ-007 The block SHALL have port key  output  2  slot select for the 4:1 sender mux / 1:4 receiver demux.
REQ-008 The block SHALL have port line_out  output  1  serial TDM line bit for the current slot.
REQ-009 The block SHALL have port frame_sync  output  1  high only during slot 00 of each frame.
REQ-010 The block SHALL have port busy  output  1  high while in SEND or GAP.
REQ-011 The block SHALL have port frame_cnt  output  8  count of completed frames.

Function
REQ-012 Outputs key, line_out, frame_sync, busy and frame_cnt SHALL be registered; din_ready SHALL be combinational from state.
REQ-013 The FSM SHALL have exactly three states, IDLE, SEND and GAP.
REQ-014 The transfer rule SHALL be: a word is accepted on a rising edge where din_valid=1 and din_ready=1; no other condition accepts a word.
REQ-015 IDLE SHALL drive din_ready=1, key=00, line_out=0, frame_sync=0, busy=0.
REQ-016 An accept from IDLE SHALL latch din into a 4-bit hold register and enter SEND with key=00 on the same edge, so the first bit appears on line_out exactly one cycle after the accept edge.
REQ-017 SEND SHALL last exactly 4 cycles, with key stepping 00, 01, 10, 11 one slot per cycle.
REQ-018 In SEND, line_out SHALL equal hold[3-key] (slot 00 -> bit3, 01 -> bit2, 10 -> bit1, 11 -> bit0).
REQ-019 frame_sync SHALL be 1 only in the SEND cycle with key=00.
REQ-020 din_ready SHALL be 0 in SEND slots 00-10 and in GAP.
REQ-021 On the edge ending slot 11, frame_cnt SHALL increment by 1 modulo 256 (255 -> 0, no saturation).
REQ-022 With GAP>0, the slot-11 edge SHALL enter GAP.
REQ-023 GAP SHALL hold for exactly GAP cycles with key=00, line_out=0, frame_sync=0, busy=1, then enter IDLE.
REQ-024 With GAP=0, din_ready SHALL be 1 in slot 11.
REQ-025 With GAP=0, an accept in slot 11 SHALL reload hold and restart SEND at key=00 with no idle cycle (back-to-back frames); otherwise the next state SHALL be IDLE.
REQ-026 din_valid while din_ready=0 SHALL be ignored, with no latch and no state change; upstream holds the word until accepted.
REQ-027 Changes on din after acceptance SHALL NOT affect the frame in progress.
REQ-028 The GAP counter SHALL be 4 bits wide and SHALL be reloaded on each entry to GAP.

Reset
REQ-029 rst=1 at a rising edge SHALL force state=IDLE, key=00, line_out=0, frame_sync=0, busy=0, frame_cnt=0, hold=0000 and GAP counter=0, regardless of current state.
REQ-030 rst asserted mid-frame SHALL abort the frame without incrementing frame_cnt, and no partial bits SHALL appear after the reset edge.
REQ-031 rst SHALL have priority over a simultaneous accept; the word presented on that edge SHALL be dropped.
REQ-032 On the first rising edge with rst=0, the block SHALL be in IDLE with din_ready=1.

Verification
REQ-033 Single frame, GAP=1: din=1011 accepted at cycle 0 -> line_out 1,0,1,1 in cycles 1-4; key 00,01,10,11; frame_sync=1 only in cycle 1; cycle 5 is GAP (busy=1, din_ready=0); cycle 6 is IDLE; frame_cnt=1.
REQ-034 Back-to-back, GAP=0: din=1000 then 0001 with din_valid held high -> line_out 1,0,0,0,0,0,0,1 in 8 consecutive cycles, frame_sync in cycles 1 and 5, frame_cnt=2.
REQ-035 Backpressure: din_valid=1 with din=0110 asserted during slot 01 of a frame -> word is not accepted until IDLE; the current frame's bits are unchanged; 0110 is sent in the following frame.
REQ-036 Reset mid-frame: rst pulsed in slot 10 of din=1111 -> next cycle key=00, line_out=0, busy=0, frame_cnt=0, din_ready=1.
REQ-037 Wrap: 256 frames sent with GAP=0 -> frame_cnt reads 255 after frame 255 and reads 0 after frame 256.
